hppb_mig_scheduler: RTL and testbench

Sequences hot-page migration. It fetches 64-byte address-pair lines from a host-resident ring buffer over an AXI read port and unpacks each line into 8 src/dst page pairs. It deals the pairs alternately to the two migration channels through valid/ready handshakes and counts completions. It sits between the CSR block and the two-channel page-copy engines, and replaces the CSR-debug address generation path.

---
 rtl/hppb_mig_scheduler_if.sv | 27 ++
 rtl/hppb_mig_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_hppb_mig_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hppb_mig_scheduler_if.sv
// AXI4 read-only port used by the hot-page migration scheduler to fetch
// 64-byte address-pair lines from the host ring buffer.
//   master : scheduler side (drives AR channel and rready)
//   slave  : fabric/memory side (drives arready and the R channel)
interface hppb_mig_scheduler_if;
  logic [11:0]  hppb_arid;
  logic [63:0]  hppb_araddr;
  logic         hppb_arvalid;
  logic [5:0]   hppb_aruser;
  logic         hppb_arready;
  logic [11:0]  hppb_rid;
  logic [511:0] hppb_rdata;
  logic [1:0]   hppb_rresp;
  logic         hppb_rvalid;
  logic         hppb_rlast;
  logic         hppb_rready;

  modport master (
    output hppb_arid, hppb_araddr, hppb_arvalid, hppb_aruser, hppb_rready,
    input  hppb_arready, hppb_rid, hppb_rdata, hppb_rresp, hppb_rvalid, hppb_rlast
  );

  modport slave (
    input  hppb_arid, hppb_araddr, hppb_arvalid, hppb_aruser, hppb_rready,
    output hppb_arready, hppb_rid, hppb_rdata, hppb_rresp, hppb_rvalid, hppb_rlast
  );
endinterface

// File: rtl/hppb_mig_scheduler.sv
// Hot-page migration scheduler.
// Fetches one 64B line at a time from a host ring (base + line_ptr*64),
// unpacks it into 8 src/dst page pairs and deals even pairs to channel 0 and
// odd pairs to channel 1. A line retires once every dispatched page has
// reported done (or immediately when the read returns an error response).
// Ports:
//   axi4_mm_clk / axi4_mm_rst   clock, synchronous active-high reset
//   csr_buf_base_paddr          ring base byte address (0 disables fetching)
//   csr_aruser                  aruser for ring reads
//   csr_hppb_mig_start_cnt      lines published by software
//   axi                         AXI read port (AR/R)
//   chN_*                       per-channel pair handshake and done pulse
//   lines_done_cnt/mig_done_cnt retired lines / completed pages
//   rd_err_cnt                  lines dropped on read error (saturating)
//   protocol_err                sticky: done pulse with nothing outstanding
//   busy                        scheduler not idle
module hppb_mig_scheduler #(
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned PAIRS_PER_LINE = 8
) (
  input  logic                        axi4_mm_clk,
  input  logic                        axi4_mm_rst,
  input  logic [63:0]                 csr_buf_base_paddr,
  input  logic [5:0]                  csr_aruser,
  input  logic [63:0]                 csr_hppb_mig_start_cnt,
  hppb_mig_scheduler_if.master        axi,
  output logic [63:0]                 ch0_src_addr,
  output logic [63:0]                 ch0_dst_addr,
  output logic                        ch0_valid,
  input  logic                        ch0_ready,
  input  logic                        ch0_done,
  output logic [63:0]                 ch1_src_addr,
  output logic [63:0]                 ch1_dst_addr,
  output logic                        ch1_valid,
  input  logic                        ch1_ready,
  input  logic                        ch1_done,
  output logic [63:0]                 lines_done_cnt,
  output logic [63:0]                 mig_done_cnt,
  output logic [15:0]                 rd_err_cnt,
  output logic                        protocol_err,
  output logic                        busy
);

  localparam int unsigned PTR_W  = $clog2(NUM_LINES);
  localparam int unsigned PER_CH = PAIRS_PER_LINE / 2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_AR       = 3'd1;
  localparam logic [2:0] S_RWAIT    = 3'd2;
  localparam logic [2:0] S_DISPATCH = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;

  logic [2:0]       state;
  logic [PTR_W-1:0] line_ptr;
  logic [63:0]      rd_addr;
  logic [5:0]       aruser_q;
  logic [511:0]     line_buf;
  logic [2:0]       ptr0;
  logic [2:0]       ptr1;
  logic [4:0]       outstanding;

  logic             found0, found1;
  logic [1:0]       sel0, sel1;
  logic [31:0]      src0_page, dst0_page, src1_page, dst1_page;
  logic             hs0, hs1;
  logic [1:0]       inc, dec;
  logic             rid_match;
  logic             unused_r;

  assign unused_r = ^{axi.hppb_rresp[0], axi.hppb_rlast};

  // Next non-hole pair at or after each channel's index. Holes are skipped
  // combinationally so they cost no cycles.
  always_comb begin
    found0    = 1'b0;
    sel0      = '0;
    src0_page = '0;
    dst0_page = '0;
    found1    = 1'b0;
    sel1      = '0;
    src1_page = '0;
    dst1_page = '0;
    for (int unsigned j = 0; j < PER_CH; j++) begin
      if (!found0 && 3'(j) >= ptr0 && line_buf[128*j +: 32] != '0) begin
        found0    = 1'b1;
        sel0      = 2'(j);
        src0_page = line_buf[128*j +: 32];
        dst0_page = line_buf[128*j+32 +: 32];
      end
      if (!found1 && 3'(j) >= ptr1 && line_buf[128*j+64 +: 32] != '0) begin
        found1    = 1'b1;
        sel1      = 2'(j);
        src1_page = line_buf[128*j+64 +: 32];
        dst1_page = line_buf[128*j+96 +: 32];
      end
    end
  end

  assign ch0_valid    = (state == S_DISPATCH) && found0;
  assign ch1_valid    = (state == S_DISPATCH) && found1;
  // Addresses come straight from the captured line and the registered index,
  // so they cannot move while a channel is stalled.
  assign ch0_src_addr = ch0_valid ? {20'b0, src0_page, 12'b0} : '0;
  assign ch0_dst_addr = ch0_valid ? {20'b0, dst0_page, 12'b0} : '0;
  assign ch1_src_addr = ch1_valid ? {20'b0, src1_page, 12'b0} : '0;
  assign ch1_dst_addr = ch1_valid ? {20'b0, dst1_page, 12'b0} : '0;

  assign hs0 = ch0_valid && ch0_ready;
  assign hs1 = ch1_valid && ch1_ready;
  assign inc = {1'b0, hs0} + {1'b0, hs1};
  assign dec = {1'b0, ch0_done} + {1'b0, ch1_done};

  assign axi.hppb_arvalid = (state == S_AR);
  assign axi.hppb_araddr  = rd_addr;
  assign axi.hppb_arid    = 12'(line_ptr);
  assign axi.hppb_aruser  = aruser_q;
  assign axi.hppb_rready  = (state == S_RWAIT);
  assign rid_match        = (axi.hppb_rid == 12'(line_ptr));

  assign busy = (state != S_IDLE);

  always_ff @(posedge axi4_mm_clk) begin
    if (axi4_mm_rst) begin
      state          <= S_IDLE;
      line_ptr       <= '0;
      rd_addr        <= '0;
      aruser_q       <= '0;
      line_buf       <= '0;
      ptr0           <= '0;
      ptr1           <= '0;
      outstanding    <= '0;
      lines_done_cnt <= '0;
      mig_done_cnt   <= '0;
      rd_err_cnt     <= '0;
      protocol_err   <= 1'b0;
    end else begin
      mig_done_cnt <= mig_done_cnt + 64'(ch0_done) + 64'(ch1_done);

      // A done with nothing outstanding is flagged and not allowed to
      // underflow the counter; accepted handshakes still count.
      if (dec != '0 && outstanding == '0)
        protocol_err <= 1'b1;
      if (5'(dec) > outstanding)
        outstanding <= 5'(inc);
      else
        outstanding <= outstanding + 5'(inc) - 5'(dec);

      case (state)
        S_IDLE: begin
          if (csr_hppb_mig_start_cnt != lines_done_cnt && csr_buf_base_paddr != '0) begin
            rd_addr  <= csr_buf_base_paddr + (64'(line_ptr) << 6);
            aruser_q <= csr_aruser;
            state    <= S_AR;
          end
        end
        S_AR: begin
          if (axi.hppb_arready)
            state <= S_RWAIT;
        end
        S_RWAIT: begin
          if (axi.hppb_rvalid && rid_match) begin
            line_buf <= axi.hppb_rdata;
            if (axi.hppb_rresp[1]) begin
              if (rd_err_cnt != '1)
                rd_err_cnt <= rd_err_cnt + 16'd1;
              lines_done_cnt <= lines_done_cnt + 64'd1;
              line_ptr       <= line_ptr + PTR_W'(1);
              state          <= S_IDLE;
            end else begin
              ptr0  <= '0;
              ptr1  <= '0;
              state <= S_DISPATCH;
            end
          end
        end
        S_DISPATCH: begin
          if (hs0)
            ptr0 <= {1'b0, sel0} + 3'd1;
          if (hs1)
            ptr1 <= {1'b0, sel1} + 3'd1;
          if (!found0 && !found1)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (outstanding == '0) begin
            lines_done_cnt <= lines_done_cnt + 64'd1;
            line_ptr       <= line_ptr + PTR_W'(1);
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hppb_mig_scheduler.sv
// Directed bench for hppb_mig_scheduler. A single cycle() task drives all DUT
// inputs for the next rising edge (AXI slave model plus two channel models)
// and records the handshakes that edge will complete.
module tb_hppb_mig_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] base = '0;
  logic [5:0]  aruser = '0;
  logic [63:0] start_cnt = '0;
  logic [63:0] ch0_src, ch0_dst, ch1_src, ch1_dst;
  logic        ch0_valid, ch1_valid;
  logic        ch0_ready = 1'b0, ch1_ready = 1'b0, ch0_done = 1'b0, ch1_done = 1'b0;
  logic [63:0] lines_done, mig_done;
  logic [15:0] rd_err;
  logic        protocol_err, busy;

  hppb_mig_scheduler_if axi();

  always #5 clk = ~clk;

  hppb_mig_scheduler #(.NUM_LINES(16), .PAIRS_PER_LINE(8)) dut (
    .axi4_mm_clk(clk), .axi4_mm_rst(rst),
    .csr_buf_base_paddr(base), .csr_aruser(aruser), .csr_hppb_mig_start_cnt(start_cnt),
    .axi(axi),
    .ch0_src_addr(ch0_src), .ch0_dst_addr(ch0_dst), .ch0_valid(ch0_valid),
    .ch0_ready(ch0_ready), .ch0_done(ch0_done),
    .ch1_src_addr(ch1_src), .ch1_dst_addr(ch1_dst), .ch1_valid(ch1_valid),
    .ch1_ready(ch1_ready), .ch1_done(ch1_done),
    .lines_done_cnt(lines_done), .mig_done_cnt(mig_done), .rd_err_cnt(rd_err),
    .protocol_err(protocol_err), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  logic [511:0] line_q[$];
  logic [1:0]   resp_q[$];
  logic [63:0]  araddr_log[$];
  logic [11:0]  arid_log[$];
  logic [5:0]   aruser_log[$];
  logic [63:0]  src0_q[$], dst0_q[$], src1_q[$], dst1_q[$];

  bit          rdy0_en, rdy1_en, done_en, force_done1, bad_rid_once, beat_bad, any_valid;
  int          pend0, pend1, r_state, r_wait, both_cycles;
  logic [11:0] r_id;
  logic [63:0] max_step;

  function automatic logic [511:0] mk_line(input logic [31:0] sb, input logic [31:0] db,
                                           input logic [7:0] holes);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) begin
      l[64*k +: 32]    = holes[k] ? 32'h0 : sb + 32'(k);
      l[64*k+32 +: 32] = db + 32'(k);
    end
    return l;
  endfunction

  task automatic cycle();
    bit h0, h1;
    if (rst) begin
      ch0_ready = 1'b0; ch1_ready = 1'b0; ch0_done = 1'b0; ch1_done = 1'b0;
      axi.hppb_arready = 1'b0; axi.hppb_rvalid = 1'b0; axi.hppb_rlast = 1'b0;
      pend0 = 0; pend1 = 0; r_state = 0; force_done1 = 1'b0; beat_bad = 1'b0;
    end else begin
      ch0_ready = rdy0_en;
      ch1_ready = rdy1_en;
      ch0_done  = done_en && pend0 > 0;
      if (ch0_done) pend0--;
      ch1_done  = (done_en && pend1 > 0) || force_done1;
      if (done_en && pend1 > 0) pend1--;
      force_done1 = 1'b0;
      axi.hppb_arready = 1'b1;
      if (r_state == 1) begin
        if (r_wait > 0) r_wait--;
        else begin
          if (bad_rid_once) begin
            axi.hppb_rid   = r_id ^ 12'h800;
            axi.hppb_rdata = {8{32'h0000_0555, 32'h0000_0777}};
            axi.hppb_rresp = 2'b00;
            beat_bad = 1'b1; bad_rid_once = 1'b0;
          end else begin
            axi.hppb_rid   = r_id;
            axi.hppb_rdata = (line_q.size() > 0) ? line_q.pop_front() : '0;
            axi.hppb_rresp = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
          end
          r_state = 2;
        end
      end
      axi.hppb_rvalid = (r_state == 2);
      axi.hppb_rlast  = (r_state == 2);
      if (axi.hppb_arvalid && axi.hppb_arready) begin
        araddr_log.push_back(axi.hppb_araddr);
        arid_log.push_back(axi.hppb_arid);
        aruser_log.push_back(axi.hppb_aruser);
        r_state = 1; r_wait = 1; r_id = axi.hppb_arid;
      end
      if (r_state == 2 && axi.hppb_rready) begin
        if (beat_bad) begin r_state = 1; r_wait = 0; beat_bad = 1'b0; end
        else r_state = 0;
      end
      h0 = ch0_valid && ch0_ready;
      h1 = ch1_valid && ch1_ready;
      if (h0) begin src0_q.push_back(ch0_src); dst0_q.push_back(ch0_dst); pend0++; end
      if (h1) begin src1_q.push_back(ch1_src); dst1_q.push_back(ch1_dst); pend1++; end
      if (ch0_valid || ch1_valid) any_valid = 1'b1;
      if (h0 && h1 && ch0_done && ch1_done) both_cycles++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    line_q.delete(); resp_q.delete(); araddr_log.delete(); arid_log.delete(); aruser_log.delete();
    src0_q.delete(); dst0_q.delete(); src1_q.delete(); dst1_q.delete();
    any_valid = 1'b0; both_cycles = 0; max_step = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_cnt = '0;
    cycle(); cycle();
    rst = 1'b0;
    rdy0_en = 1'b1; rdy1_en = 1'b1; done_en = 1'b1; bad_rid_once = 1'b0;
    clear_logs();
  endtask

  task automatic wait_lines(input logic [63:0] target, input int bound, output bit ok);
    logic [63:0] prev;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      prev = mig_done;
      cycle();
      if (mig_done - prev > max_step) max_step = mig_done - prev;
      if (lines_done == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; base = 64'h1000_0000; start_cnt = 64'd1;
    cycle(); cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (axi.hppb_arvalid !== 1'b0 || axi.hppb_rready !== 1'b0) begin errors++;
      $display("FAIL reset_axi: arvalid=%0b rready=%0b expected 0/0", axi.hppb_arvalid, axi.hppb_rready); end
    checks++; if (ch0_valid !== 1'b0 || ch1_valid !== 1'b0 || ch0_src !== 64'h0 || ch1_dst !== 64'h0) begin errors++;
      $display("FAIL reset_ch: v0=%0b v1=%0b src0=%0h dst1=%0h expected all 0", ch0_valid, ch1_valid, ch0_src, ch1_dst); end
    checks++; if (lines_done !== 64'h0 || mig_done !== 64'h0 || rd_err !== 16'h0 || protocol_err !== 1'b0) begin errors++;
      $display("FAIL reset_cnt: lines=%0h mig=%0h rderr=%0h perr=%0b expected 0", lines_done, mig_done, rd_err, protocol_err); end
    checks++; if (axi.hppb_araddr !== 64'h0 || axi.hppb_arid !== 12'h0) begin errors++;
      $display("FAIL reset_ar: araddr=%0h arid=%0h expected 0", axi.hppb_araddr, axi.hppb_arid); end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    base = 64'h1000_0000; aruser = 6'h2A; start_cnt = 64'd1;
    line_q.push_back(mk_line(32'h100, 32'h200, 8'h00));
    wait_lines(64'd1, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: lines=%0d expected 1", lines_done); end
    checks++; if (araddr_log.size() != 1 || araddr_log[0] !== 64'h1000_0000 || arid_log[0] !== 12'h0) begin errors++;
      $display("FAIL basic_ar: n=%0d araddr=%0h arid=%0h expected 1/10000000/0", araddr_log.size(), araddr_log[0], arid_log[0]); end
    checks++; if (aruser_log.size() != 1 || aruser_log[0] !== 6'h2A) begin errors++;
      $display("FAIL basic_aruser: got %0h expected 2a", aruser_log[0]); end
    checks++; if (src0_q.size() != 4 || src1_q.size() != 4) begin errors++;
      $display("FAIL basic_hs_count: ch0=%0d ch1=%0d expected 4/4", src0_q.size(), src1_q.size()); end
    for (int j = 0; j < 4 && j < src0_q.size() && j < src1_q.size(); j++) begin
      checks++;
      if (src0_q[j] !== (64'(32'h100 + 32'(2*j)) << 12) || dst0_q[j] !== (64'(32'h200 + 32'(2*j)) << 12)) begin errors++;
        $display("FAIL basic_ch0[%0d]: got %0h/%0h expected %0h/%0h", j, src0_q[j], dst0_q[j],
                 64'(32'h100 + 32'(2*j)) << 12, 64'(32'h200 + 32'(2*j)) << 12); end
      checks++;
      if (src1_q[j] !== (64'(32'h101 + 32'(2*j)) << 12) || dst1_q[j] !== (64'(32'h201 + 32'(2*j)) << 12)) begin errors++;
        $display("FAIL basic_ch1[%0d]: got %0h/%0h expected %0h/%0h", j, src1_q[j], dst1_q[j],
                 64'(32'h101 + 32'(2*j)) << 12, 64'(32'h201 + 32'(2*j)) << 12); end
    end
    checks++; if (lines_done !== 64'd1 || mig_done !== 64'd8) begin errors++;
      $display("FAIL basic_counts: lines=%0d mig=%0d expected 1/8", lines_done, mig_done); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL basic_perr: got %0b expected 0", protocol_err); end
  endtask

  task automatic test_back_to_back();
    checks++; if (both_cycles < 1) begin errors++;
      $display("FAIL b2b_overlap: cycles with 2 accepts+2 dones=%0d expected >=1", both_cycles); end
    checks++; if (max_step !== 64'd2) begin errors++;
      $display("FAIL b2b_mig_step: max mig_done step=%0d expected 2", max_step); end
  endtask

  task automatic test_protocol_err();
    force_done1 = 1'b1;
    cycle();
    checks++; if (protocol_err !== 1'b1 || mig_done !== 64'd9) begin errors++;
      $display("FAIL perr_set: perr=%0b mig=%0d expected 1/9", protocol_err, mig_done); end
    cycle(); cycle(); cycle();
    checks++; if (protocol_err !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL perr_sticky: perr=%0b busy=%0b expected 1/0", protocol_err, busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    base = 64'h2000_0000; start_cnt = 64'd17;
    wait_lines(64'd17, 400, ok);
    checks++; if (!ok || araddr_log.size() != 17) begin errors++;
      $display("FAIL wrap_done: ok=%0b reads=%0d lines=%0d expected 1/17/17", ok, araddr_log.size(), lines_done); end
    for (int i = 0; i < araddr_log.size(); i++) begin
      checks++;
      if (araddr_log[i] !== 64'h2000_0000 + 64'((i % 16) * 64) || arid_log[i] !== 12'(i % 16)) begin errors++;
        $display("FAIL wrap_ar[%0d]: araddr=%0h arid=%0h expected %0h/%0h", i, araddr_log[i], arid_log[i],
                 64'h2000_0000 + 64'((i % 16) * 64), i % 16); end
    end
    for (int i = 0; i < 5; i++) cycle();
    checks++; if (araddr_log.size() != 17 || busy !== 1'b0 || mig_done !== 64'd0) begin errors++;
      $display("FAIL wrap_stop: reads=%0d busy=%0b mig=%0d expected 17/0/0", araddr_log.size(), busy, mig_done); end
  endtask

  task automatic test_holes();
    bit ok;
    do_reset();
    base = 64'h1000_0000; start_cnt = 64'd1;
    line_q.push_back(mk_line(32'h300, 32'h400, 8'h52));
    wait_lines(64'd1, 80, ok);
    checks++; if (!ok || src0_q.size() != 2 || src1_q.size() != 3) begin errors++;
      $display("FAIL holes_count: ok=%0b ch0=%0d ch1=%0d expected 1/2/3", ok, src0_q.size(), src1_q.size()); end
    if (src0_q.size() == 2 && src1_q.size() == 3) begin
      checks++;
      if (src0_q[0] !== 64'h30_0000 || src0_q[1] !== 64'h30_2000 || dst0_q[1] !== 64'h40_2000) begin errors++;
        $display("FAIL holes_ch0: got %0h,%0h dst %0h expected 300000,302000 dst 402000", src0_q[0], src0_q[1], dst0_q[1]); end
      checks++;
      if (src1_q[0] !== 64'h30_3000 || src1_q[1] !== 64'h30_5000 || src1_q[2] !== 64'h30_7000) begin errors++;
        $display("FAIL holes_ch1: got %0h,%0h,%0h expected 303000,305000,307000", src1_q[0], src1_q[1], src1_q[2]); end
    end
    checks++; if (mig_done !== 64'd5) begin errors++; $display("FAIL holes_mig: got %0d expected 5", mig_done); end
    start_cnt = 64'd2;
    line_q.push_back('0);
    wait_lines(64'd2, 80, ok);
    checks++; if (!ok || src0_q.size() + src1_q.size() != 5 || araddr_log.size() != 2) begin errors++;
      $display("FAIL holes_empty_line: ok=%0b hs=%0d reads=%0d expected 1/5/2", ok, src0_q.size() + src1_q.size(), araddr_log.size()); end
    else if (araddr_log[1] !== 64'h1000_0040) begin checks++; errors++;
      $display("FAIL holes_addr2: got %0h expected 10000040", araddr_log[1]); end
  endtask

  task automatic test_rd_err();
    bit ok;
    do_reset();
    base = 64'h1000_0000; start_cnt = 64'd1;
    line_q.push_back(mk_line(32'h100, 32'h200, 8'h00));
    resp_q.push_back(2'b10);
    wait_lines(64'd1, 80, ok);
    checks++; if (!ok || any_valid || rd_err !== 16'd1) begin errors++;
      $display("FAIL rderr_drop: ok=%0b any_valid=%0b rderr=%0d expected 1/0/1", ok, any_valid, rd_err); end
    start_cnt = 64'd2; bad_rid_once = 1'b1;
    line_q.push_back('0);
    wait_lines(64'd2, 80, ok);
    checks++; if (!ok || araddr_log.size() != 2) begin errors++;
      $display("FAIL rderr_next: ok=%0b reads=%0d expected 1/2", ok, araddr_log.size()); end
    else begin
      checks++; if (araddr_log[1] !== 64'h1000_0040 || arid_log[1] !== 12'd1) begin errors++;
        $display("FAIL rderr_addr: araddr=%0h arid=%0h expected 10000040/1", araddr_log[1], arid_log[1]); end
    end
    checks++; if (src0_q.size() + src1_q.size() != 0 || rd_err !== 16'd1) begin errors++;
      $display("FAIL rid_discard: hs=%0d rderr=%0d expected 0/1", src0_q.size() + src1_q.size(), rd_err); end
  endtask

  task automatic test_backpressure();
    bit ok, seen, stable;
    do_reset();
    base = 64'h1000_0000; start_cnt = 64'd1; rdy0_en = 1'b0;
    line_q.push_back(mk_line(32'h100, 32'h200, 8'h00));
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin cycle(); seen = ch0_valid; end
    checks++; if (!seen) begin errors++; $display("FAIL bp_valid: ch0_valid never rose, expected 1"); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (ch0_valid !== 1'b1 || ch0_src !== 64'h10_0000 || ch0_dst !== 64'h20_0000) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++;
      $display("FAIL bp_stable: src0=%0h dst0=%0h v=%0b expected 100000/200000/1", ch0_src, ch0_dst, ch0_valid); end
    checks++; if (src0_q.size() != 0 || src1_q.size() != 4) begin errors++;
      $display("FAIL bp_independent: ch0=%0d ch1=%0d expected 0/4", src0_q.size(), src1_q.size()); end
    rdy0_en = 1'b1;
    wait_lines(64'd1, 80, ok);
    checks++; if (!ok || mig_done !== 64'd8 || src0_q.size() != 4) begin errors++;
      $display("FAIL bp_finish: ok=%0b mig=%0d ch0=%0d expected 1/8/4", ok, mig_done, src0_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    base = 64'h1000_0000; start_cnt = 64'd1; rdy1_en = 1'b0;
    line_q.push_back(mk_line(32'h100, 32'h200, 8'h00));
    for (int i = 0; i < 60 && src0_q.size() < 3; i++) cycle();
    checks++; if (src0_q.size() != 3 || mig_done == 64'd0) begin errors++;
      $display("FAIL rstmid_setup: accepts=%0d mig=%0d expected 3/>0", src0_q.size(), mig_done); end
    rst = 1'b1; rdy0_en = 1'b0;
    cycle();
    checks++; if (busy !== 1'b0 || ch0_valid !== 1'b0 || ch1_valid !== 1'b0 || ch0_src !== 64'h0 ||
                  axi.hppb_arvalid !== 1'b0 || axi.hppb_rready !== 1'b0) begin errors++;
      $display("FAIL rstmid_outputs: busy=%0b v0=%0b v1=%0b src0=%0h arv=%0b rr=%0b expected all 0",
               busy, ch0_valid, ch1_valid, ch0_src, axi.hppb_arvalid, axi.hppb_rready); end
    checks++; if (mig_done !== 64'd0 || lines_done !== 64'd0 || protocol_err !== 1'b0) begin errors++;
      $display("FAIL rstmid_counts: mig=%0d lines=%0d perr=%0b expected 0/0/0", mig_done, lines_done, protocol_err); end
    rst = 1'b0; rdy0_en = 1'b1; rdy1_en = 1'b1;
    clear_logs();
    line_q.push_back(mk_line(32'h100, 32'h200, 8'h00));
    wait_lines(64'd1, 80, ok);
    checks++; if (!ok || araddr_log.size() != 1 || mig_done !== 64'd8) begin errors++;
      $display("FAIL rstmid_refetch: ok=%0b reads=%0d mig=%0d expected 1/1/8", ok, araddr_log.size(), mig_done); end
    else begin
      checks++; if (araddr_log[0] !== 64'h1000_0000) begin errors++;
        $display("FAIL rstmid_addr: got %0h expected 10000000", araddr_log[0]); end
    end
  endtask

  initial begin
    axi.hppb_arready = 1'b0; axi.hppb_rvalid = 1'b0; axi.hppb_rlast = 1'b0;
    axi.hppb_rid = '0; axi.hppb_rdata = '0; axi.hppb_rresp = '0;
    rdy0_en = 1'b1; rdy1_en = 1'b1; done_en = 1'b1; force_done1 = 1'b0;
    bad_rid_once = 1'b0; beat_bad = 1'b0; pend0 = 0; pend1 = 0; r_state = 0; r_wait = 0; r_id = '0;
    clear_logs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_protocol_err();
    test_wrap();
    test_holes();
    test_rd_err();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
